multicycle_computer_controller_main_fsm: RTL and testbench

Main control state machine of the multicycle computer controller. Sequences every instruction through fetch, decode, execute, memory and writeback, and drives the 4-bit `current_state` consumed by the ALU decoder. It also produces all datapath strobes and mux selects for the register file, memory, instruction register, PC and flags. Control outputs are a Moore decode of `current_state`; the few that also depend on instruction fields are noted per state.

---
 rtl/multicycle_computer_controller_main_fsm.sv | 109 ++++++++++
 tb/tb_multicycle_computer_controller_main_fsm.sv | 117 +++++++++++
 2 files changed

// File: rtl/multicycle_computer_controller_main_fsm.sv
// multicycle_computer_controller_main_fsm: main control FSM of the multicycle computer; MC_FSM_BL_EN enables the BL link state.
module multicycle_computer_controller_main_fsm (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] INSTRUCTION,
  input  logic        COND_EX,
  output logic [3:0]  current_state,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        FlagWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        LinkReg
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXEC_R   = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] EXEC_I   = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] LINK     = 4'd10;
  localparam logic [3:0] SHIFT    = 4'd11;
  localparam logic [3:0] CMP_R    = 4'd12;
  localparam logic [3:0] CMP_I    = 4'd15;
  logic [3:0] state, next_state, st, decode_next, br_next;
  logic [1:0] op;
  logic [3:0] cmd, rd;
  logic       imm, sbit;
  logic       pcw, irw, mw, rw, fw, lr;
  logic       unused;
  assign op   = INSTRUCTION[27:26];
  assign imm  = INSTRUCTION[25];
  assign cmd  = INSTRUCTION[24:21];
  assign sbit = INSTRUCTION[20];
  assign rd   = INSTRUCTION[15:12];
`ifdef MC_FSM_BL_EN
  assign br_next = INSTRUCTION[24] ? LINK : BRANCH;
  assign LinkReg = lr;
  assign unused  = ^{INSTRUCTION[31:28], INSTRUCTION[19:16], INSTRUCTION[11:0]};
`else
  assign br_next = BRANCH;
  assign LinkReg = 1'b0;
  assign unused  = ^{INSTRUCTION[31:28], INSTRUCTION[19:16], INSTRUCTION[11:0], lr};
`endif
  assign decode_next = !COND_EX              ? FETCH  :
                       op == 2'b01           ? MEMADR :
                       op == 2'b10           ? br_next :
                       op == 2'b11           ? FETCH  :
                       cmd[3:2] == 2'b10     ? (imm ? CMP_I : CMP_R) :
                       cmd == 4'b1101        ? SHIFT  :
                       imm                   ? EXEC_I : EXEC_R;
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = decode_next;
      MEMADR:  next_state = sbit ? MEMREAD : MEMWRITE;
      MEMREAD: next_state = MEMWB;
      EXEC_R:  next_state = ALUWB;
      EXEC_I:  next_state = ALUWB;
      SHIFT:   next_state = ALUWB;
      LINK:    next_state = BRANCH;
      default: next_state = FETCH;
    endcase
  end
  always_ff @(posedge CLK)
    if (!RESET_N) state <= FETCH;
    else state <= next_state;
  assign current_state = state;
  // Under reset the selects mirror FETCH while every write strobe is held off.
  assign st = RESET_N ? state : FETCH;
  always_comb begin
    {pcw, irw, mw, rw, fw, lr} = '0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (st)
      FETCH:    begin pcw = 1'b1; irw = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; rw = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; end
      EXEC_R:   fw = sbit;
      EXEC_I:   begin ALUSrcB = 2'b01; fw = sbit; end
      SHIFT:    fw = sbit;
      ALUWB:    begin rw = 1'b1; pcw = rd == 4'hF; end
      CMP_R:    fw = 1'b1;
      CMP_I:    begin ALUSrcB = 2'b01; fw = 1'b1; end
      BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; pcw = 1'b1; end
      LINK:     begin rw = 1'b1; lr = 1'b1; ResultSrc = 2'b11; end
      default:  ;
    endcase
  end
  assign PCWrite   = RESET_N & pcw;
  assign IRWrite   = RESET_N & irw;
  assign MemWrite  = RESET_N & mw;
  assign RegWrite  = RESET_N & rw;
  assign FlagWrite = RESET_N & fw;
endmodule

// File: tb/tb_multicycle_computer_controller_main_fsm.sv
// tb_multicycle_computer_controller_main_fsm: scoreboard bench checking state sequences and control vectors per instruction.
module tb_multicycle_computer_controller_main_fsm;
  logic        CLK = 1'b0, RESET_N, COND_EX;
  logic [31:0] INSTRUCTION;
  logic [3:0]  current_state;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, FlagWrite, AdrSrc, ALUSrcA, LinkReg;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic [11:0] ctl;
  int passed = 0, total = 0;
  logic [15:0] q[$];
  multicycle_computer_controller_main_fsm dut (
    .CLK(CLK), .RESET_N(RESET_N), .INSTRUCTION(INSTRUCTION), .COND_EX(COND_EX),
    .current_state(current_state), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .FlagWrite(FlagWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .LinkReg(LinkReg)
  );
  always #5 CLK = ~CLK;
  // {PCWrite,IRWrite,MemWrite,RegWrite,FlagWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,LinkReg}
  assign ctl = {PCWrite, IRWrite, MemWrite, RegWrite, FlagWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, LinkReg};
  localparam logic [11:0] C_FETCH = 12'b1100_0011_0100;
  localparam logic [11:0] C_DEC   = 12'b0000_0011_0100;
  localparam logic [11:0] C_RST   = 12'b0000_0011_0100;
  localparam logic [11:0] C_ADR   = 12'b0000_0000_1000;
  localparam logic [11:0] C_MRD   = 12'b0000_0100_0000;
  localparam logic [11:0] C_MWB   = 12'b0001_0000_0010;
  localparam logic [11:0] C_MWR   = 12'b0010_0100_0000;
  localparam logic [11:0] C_FW    = 12'b0000_1000_0000;
  localparam logic [11:0] C_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] C_WB    = 12'b0001_0000_0000;
  localparam logic [11:0] C_WBPC  = 12'b1001_0000_0000;
  localparam logic [11:0] C_CMPI  = 12'b0000_1000_1000;
  localparam logic [11:0] C_LINK  = 12'b0001_0000_0111;
  localparam logic [11:0] C_BR    = 12'b1000_0000_1100;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic push(input logic [3:0] s, input logic [11:0] c);
    q.push_back({s, c});
  endtask
  task automatic run(input string name, input logic [31:0] ins, input logic c);
    logic [15:0] e;
    int k = 0;
    INSTRUCTION = ins;
    COND_EX = c;
    while (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("%s state step%0d", name, k), {12'd0, current_state}, {12'd0, e[15:12]});
      check($sformatf("%s ctl step%0d", name, k), {4'd0, ctl}, {4'd0, e[11:0]});
      k++;
      @(negedge CLK); #1;
    end
  endtask
  initial begin
    RESET_N = 1'b0;
    COND_EX = 1'b1;
    INSTRUCTION = $urandom;
    repeat (3) begin
      @(negedge CLK); #1;
      check("reset state", {12'd0, current_state}, 16'd0);
      check("reset ctl", {4'd0, ctl}, {4'd0, C_RST});
      INSTRUCTION = $urandom;
    end
    RESET_N = 1'b1; #1;
    push(0, C_FETCH); push(1, C_DEC); push(2, C_ADR); push(3, C_MRD); push(4, C_MWB);
    run("ldr", 32'hE5912004, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(6, C_FW); push(7, C_WB);
    run("adds", 32'hE0912003, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(15, C_CMPI);
    run("cmpi", 32'hE3510005, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(12, C_FW);
    run("cmpr", 32'hE1510002, 1'b1);
`ifdef MC_FSM_BL_EN
    push(0, C_FETCH); push(1, C_DEC); push(10, C_LINK); push(9, C_BR);
`else
    push(0, C_FETCH); push(1, C_DEC); push(9, C_BR);
`endif
    run("bl", 32'hEB000010, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(9, C_BR);
    run("b", 32'hEA000010, 1'b1);
    push(0, C_FETCH); push(1, C_DEC);
    run("condfail", 32'h05812004, 1'b0);
    push(0, C_FETCH); push(1, C_DEC); push(2, C_ADR); push(5, C_MWR);
    run("str", 32'hE5812004, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(6, C_NONE); push(7, C_WBPC);
    run("add_pc", 32'hE081F002, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(11, C_NONE); push(7, C_WB);
    run("mov", 32'hE1A01002, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(8, C_ADR); push(7, C_WB);
    run("addi", 32'hE2811001, 1'b1);
    push(0, C_FETCH); push(1, C_DEC);
    run("op11", 32'hEC000000, 1'b1);
    push(0, C_FETCH); push(1, C_DEC); push(2, C_ADR);
    run("ldr_part", 32'hE5912004, 1'b1);
    RESET_N = 1'b0; #1;
    check("midreset state", {12'd0, current_state}, 16'd3);
    check("midreset ctl", {4'd0, ctl}, {4'd0, C_RST});
    @(negedge CLK); #1;
    check("midreset state after edge", {12'd0, current_state}, 16'd0);
    RESET_N = 1'b1; #1;
    check("post reset ctl", {4'd0, ctl}, {4'd0, C_FETCH});
    @(negedge CLK); #1;
    check("post reset state", {12'd0, current_state}, 16'd1);
    @(negedge CLK); #1;
    force dut.state = 4'd13;
    #1;
    check("s13 state", {12'd0, current_state}, 16'd13);
    check("s13 ctl", {4'd0, ctl}, {4'd0, C_NONE});
    release dut.state;
    @(negedge CLK); #1;
    check("s13 recovery", {12'd0, current_state}, 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
